// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, MRET and interrupts, drives the CSR trap/xret update
// pulses and redirects the front end. Single hart, M/U only.
module trap_ctrl #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ALEN     = 64,
    parameter int unsigned INTR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exc_valid,
    input  logic [3:0]          exc_cause,
    input  logic [ALEN-1:0]     exc_pc,
    input  logic [XLEN-1:0]     exc_tval,
    input  logic                mret_valid,
    input  logic [ALEN-1:0]     next_pc,
    input  logic                quiescent,
    input  logic [1:0]          privilege_mode,
    input  logic [XLEN-1:0]     mstatus,
    input  logic [INTR_LEN-1:0] mie,
    input  logic [INTR_LEN-1:0] mip,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [ALEN-1:0]     mepc,
    output logic                trap_do_update,
    output logic [XLEN-1:0]     trap_mcause,
    output logic [ALEN-1:0]     trap_mepc,
    output logic [XLEN-1:0]     trap_mtval,
    output logic                xret_do_update,
    output logic                xret_completing,
    output logic [XLEN-1:0]     xret_new_mstatus,
    output logic [1:0]          xret_new_privilege_mode,
    output logic                redirect_valid,
    output logic [ALEN-1:0]     redirect_pc,
    output logic                stall
);

    localparam int unsigned IdW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWaitQ,
        StTrap,
        StXret,
        StRedirect
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;

    logic                r_trap_do_update;
    logic [XLEN-1:0]     r_trap_mcause;
    logic [ALEN-1:0]     r_trap_mepc;
    logic [XLEN-1:0]     r_trap_mtval;
    logic                r_xret_do_update;
    logic                r_xret_completing;
    logic [XLEN-1:0]     r_xret_mstatus;
    logic [1:0]          r_xret_priv;
    logic                r_redirect_valid;
    logic [ALEN-1:0]     r_redirect_pc;
    logic                r_stall;

    logic [XLEN-1:0]     w_trap_mcause_nxt;
    logic [ALEN-1:0]     w_trap_mepc_nxt;
    logic [XLEN-1:0]     w_trap_mtval_nxt;
    logic                w_xret_completing_nxt;
    logic [XLEN-1:0]     w_xret_mstatus_nxt;
    logic [1:0]          w_xret_priv_nxt;
    logic [ALEN-1:0]     w_redirect_pc_nxt;

    logic [INTR_LEN-1:0] w_pend;
    logic                w_irq_found;
    logic [IdW-1:0]      w_irq_id;
    logic                w_irq_gen;
    logic                w_irq_take;
    logic [XLEN-1:0]     w_irq_mcause;
    logic [XLEN-1:0]     w_xret_mstatus;
    logic [ALEN-1:0]     w_mtvec_a;
    logic [ALEN-1:0]     w_tvec_base;
    logic [ALEN-1:0]     w_tvec_off;
    logic [ALEN-1:0]     w_trap_target;
    logic                w_unused_pend;

    // Fixed priority MEI > MSI > MTI, then platform bits lowest index first.
    always_comb begin
        w_pend      = mie & mip;
        w_irq_found = 1'b0;
        w_irq_id    = '0;
        if (w_pend[11]) begin
            w_irq_found = 1'b1;
            w_irq_id    = IdW'(11);
        end else if (w_pend[3]) begin
            w_irq_found = 1'b1;
            w_irq_id    = IdW'(3);
        end else if (w_pend[7]) begin
            w_irq_found = 1'b1;
            w_irq_id    = IdW'(7);
        end else begin
            for (int i = INTR_LEN - 1; i >= 16; i--) begin
                if (w_pend[i]) begin
                    w_irq_found = 1'b1;
                    w_irq_id    = IdW'(i);
                end
            end
        end
    end

    assign w_unused_pend = &{1'b0, w_pend};

    assign w_irq_gen  = (privilege_mode < 2'd3) || mstatus[3];
    assign w_irq_take = w_irq_found && w_irq_gen;

    always_comb begin
        w_irq_mcause              = '0;
        w_irq_mcause[IdW-1:0]     = w_irq_id;
        w_irq_mcause[XLEN-1]      = 1'b1;
    end

    always_comb begin
        w_xret_mstatus        = mstatus;
        w_xret_mstatus[3]     = mstatus[7];
        w_xret_mstatus[7]     = 1'b1;
        w_xret_mstatus[12:11] = 2'b00;
    end

    // Vectored mode applies only to interrupts; the latched mcause says which kind this was.
    assign w_mtvec_a     = ALEN'(mtvec);
    assign w_tvec_base   = {w_mtvec_a[ALEN-1:2], 2'b00};
    assign w_tvec_off    = ALEN'(r_trap_mcause[IdW-1:0]) << 2;
    assign w_trap_target = ((w_mtvec_a[1:0] == 2'b01) && r_trap_mcause[XLEN-1])
                         ? (w_tvec_base + w_tvec_off) : w_tvec_base;

    always_comb begin
        w_state_nxt           = r_state;
        w_trap_mcause_nxt     = r_trap_mcause;
        w_trap_mepc_nxt       = r_trap_mepc;
        w_trap_mtval_nxt      = r_trap_mtval;
        w_xret_mstatus_nxt    = r_xret_mstatus;
        w_xret_priv_nxt       = r_xret_priv;
        w_redirect_pc_nxt     = r_redirect_pc;
        w_xret_completing_nxt = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (exc_valid) begin
                    w_trap_mcause_nxt = XLEN'(exc_cause);
                    w_trap_mepc_nxt   = exc_pc;
                    w_trap_mtval_nxt  = exc_tval;
                    w_state_nxt       = StTrap;
                end else if (mret_valid) begin
                    w_xret_mstatus_nxt = w_xret_mstatus;
                    w_xret_priv_nxt    = mstatus[12:11];
                    w_state_nxt        = StXret;
                end else if (w_irq_take) begin
                    if (quiescent) begin
                        w_trap_mcause_nxt = w_irq_mcause;
                        w_trap_mepc_nxt   = next_pc;
                        w_trap_mtval_nxt  = '0;
                        w_state_nxt       = StTrap;
                    end else begin
                        w_state_nxt = StWaitQ;
                    end
                end
            end
            StWaitQ: begin
                if (quiescent) begin
                    if (w_irq_take) begin
                        w_trap_mcause_nxt = w_irq_mcause;
                        w_trap_mepc_nxt   = next_pc;
                        w_trap_mtval_nxt  = '0;
                        w_state_nxt       = StTrap;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            StTrap: begin
                w_redirect_pc_nxt = w_trap_target;
                w_state_nxt       = StRedirect;
            end
            StXret: begin
                w_redirect_pc_nxt     = mepc;
                w_xret_completing_nxt = 1'b1;
                w_state_nxt           = StRedirect;
            end
            StRedirect: begin
                // An interrupt visible now is taken before the redirect target executes.
                if (w_irq_take) begin
                    w_trap_mcause_nxt     = w_irq_mcause;
                    w_trap_mepc_nxt       = r_redirect_pc;
                    w_trap_mtval_nxt      = '0;
                    w_xret_completing_nxt = r_xret_completing;
                    w_state_nxt           = StTrap;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state           <= StIdle;
            r_trap_do_update  <= 1'b0;
            r_trap_mcause     <= '0;
            r_trap_mepc       <= '0;
            r_trap_mtval      <= '0;
            r_xret_do_update  <= 1'b0;
            r_xret_completing <= 1'b0;
            r_xret_mstatus    <= '0;
            r_xret_priv       <= 2'b00;
            r_redirect_valid  <= 1'b0;
            r_redirect_pc     <= '0;
            r_stall           <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_trap_do_update  <= (w_state_nxt == StTrap);
            r_trap_mcause     <= w_trap_mcause_nxt;
            r_trap_mepc       <= w_trap_mepc_nxt;
            r_trap_mtval      <= w_trap_mtval_nxt;
            r_xret_do_update  <= (w_state_nxt == StXret);
            r_xret_completing <= w_xret_completing_nxt;
            r_xret_mstatus    <= w_xret_mstatus_nxt;
            r_xret_priv       <= w_xret_priv_nxt;
            r_redirect_valid  <= (w_state_nxt == StRedirect);
            r_redirect_pc     <= w_redirect_pc_nxt;
            r_stall           <= (w_state_nxt != StIdle);
        end
    end

    assign trap_do_update          = r_trap_do_update;
    assign trap_mcause             = r_trap_mcause;
    assign trap_mepc               = r_trap_mepc;
    assign trap_mtval              = r_trap_mtval;
    assign xret_do_update          = r_xret_do_update;
    assign xret_completing         = r_xret_completing;
    assign xret_new_mstatus        = r_xret_mstatus;
    assign xret_new_privilege_mode = r_xret_priv;
    assign redirect_valid          = r_redirect_valid;
    assign redirect_pc             = r_redirect_pc;
    assign stall                   = r_stall;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected trap/xret payloads are queued at stimulus time and
// checked when the DUT pulses its update outputs.
module tb_trap_ctrl;

    localparam logic [63:0] Irq = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [63:0] exc_pc;
    logic [63:0] exc_tval;
    logic        mret_valid;
    logic [63:0] next_pc;
    logic        quiescent;
    logic [1:0]  privilege_mode;
    logic [63:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mip;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic        trap_do_update;
    logic [63:0] trap_mcause;
    logic [63:0] trap_mepc;
    logic [63:0] trap_mtval;
    logic        xret_do_update;
    logic        xret_completing;
    logic [63:0] xret_new_mstatus;
    logic [1:0]  xret_new_privilege_mode;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] mcause;
        logic [63:0] mepc;
        logic [63:0] mtval;
        logic [63:0] target;
    } trap_exp_t;

    typedef struct {
        logic [63:0] mstatus;
        logic [1:0]  priv;
        logic [63:0] target;
    } xret_exp_t;

    trap_exp_t trap_q[$];
    xret_exp_t xret_q[$];

    trap_ctrl #(
        .XLEN     (64),
        .ALEN     (64),
        .INTR_LEN (32)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .exc_valid               (exc_valid),
        .exc_cause               (exc_cause),
        .exc_pc                  (exc_pc),
        .exc_tval                (exc_tval),
        .mret_valid              (mret_valid),
        .next_pc                 (next_pc),
        .quiescent               (quiescent),
        .privilege_mode          (privilege_mode),
        .mstatus                 (mstatus),
        .mie                     (mie),
        .mip                     (mip),
        .mtvec                   (mtvec),
        .mepc                    (mepc),
        .trap_do_update          (trap_do_update),
        .trap_mcause             (trap_mcause),
        .trap_mepc               (trap_mepc),
        .trap_mtval              (trap_mtval),
        .xret_do_update          (xret_do_update),
        .xret_completing         (xret_completing),
        .xret_new_mstatus        (xret_new_mstatus),
        .xret_new_privilege_mode (xret_new_privilege_mode),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
        .stall                   (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] xret_model(input logic [63:0] m);
        logic [63:0] r;
        r        = m;
        r[3]     = m[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    task automatic push_trap(input logic [63:0] mc, input logic [63:0] mp,
                             input logic [63:0] mt, input logic [63:0] tgt);
        trap_exp_t e;
        e.mcause = mc;
        e.mepc   = mp;
        e.mtval  = mt;
        e.target = tgt;
        trap_q.push_back(e);
    endtask

    // Waits for the trap pulse, checks payload, mimics the CSR file masking further interrupts,
    // then checks the redirect cycle and the return to idle.
    task automatic expect_trap(input string tag);
        trap_exp_t e;
        int        k;
        k = 0;
        while (trap_do_update !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        e = trap_q.pop_front();
        chk({tag, "_pulse"}, {63'd0, trap_do_update}, 64'd1);
        if (trap_do_update !== 1'b1) return;
        chk({tag, "_mcause"}, trap_mcause, e.mcause);
        chk({tag, "_mepc"}, trap_mepc, e.mepc);
        chk({tag, "_mtval"}, trap_mtval, e.mtval);
        chk({tag, "_no_xret"}, {63'd0, xret_do_update}, 64'd0);
        chk({tag, "_stall"}, {63'd0, stall}, 64'd1);
        mstatus[3] = 1'b0;
        mip        = '0;
        @(negedge clk);
        chk({tag, "_redir_v"}, {63'd0, redirect_valid}, 64'd1);
        chk({tag, "_redir_pc"}, redirect_pc, e.target);
        chk({tag, "_redir_xc"}, {63'd0, xret_completing}, 64'd0);
        chk({tag, "_pulse_off"}, {63'd0, trap_do_update}, 64'd0);
        @(negedge clk);
        chk({tag, "_idle_stall"}, {63'd0, stall}, 64'd0);
        chk({tag, "_idle_redir"}, {63'd0, redirect_valid}, 64'd0);
    endtask

    task automatic expect_xret(input string tag);
        xret_exp_t e;
        e = xret_q.pop_front();
        chk({tag, "_pulse"}, {63'd0, xret_do_update}, 64'd1);
        chk({tag, "_no_trap"}, {63'd0, trap_do_update}, 64'd0);
        chk({tag, "_mstatus"}, xret_new_mstatus, e.mstatus);
        chk({tag, "_priv"}, {62'd0, xret_new_privilege_mode}, {62'd0, e.priv});
        @(negedge clk);
        chk({tag, "_redir_v"}, {63'd0, redirect_valid}, 64'd1);
        chk({tag, "_redir_pc"}, redirect_pc, e.target);
        chk({tag, "_xc"}, {63'd0, xret_completing}, 64'd1);
        chk({tag, "_pulse_off"}, {63'd0, xret_do_update}, 64'd0);
        @(negedge clk);
        chk({tag, "_idle_stall"}, {63'd0, stall}, 64'd0);
        chk({tag, "_idle_xc"}, {63'd0, xret_completing}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) chk("pulse_excl", {63'd0, trap_do_update & xret_do_update}, 64'd0);
    end

    initial begin
        xret_exp_t x;

        rst            = 1'b0;
        exc_valid      = 1'b0;
        exc_cause      = '0;
        exc_pc         = '0;
        exc_tval       = '0;
        mret_valid     = 1'b0;
        next_pc        = 64'h8000_0100;
        quiescent      = 1'b1;
        privilege_mode = 2'd3;
        mstatus        = '0;
        mie            = '0;
        mip            = '0;
        mtvec          = 64'h100;
        mepc           = '0;
        repeat (3) @(negedge clk);
        chk("rst_trap", {63'd0, trap_do_update}, 64'd0);
        chk("rst_xret", {63'd0, xret_do_update}, 64'd0);
        chk("rst_redir", {63'd0, redirect_valid}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_xc", {63'd0, xret_completing}, 64'd0);
        chk("rst_mcause", trap_mcause, 64'd0);
        chk("rst_rpc", redirect_pc, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Illegal instruction exception.
        exc_valid = 1'b1;
        exc_cause = 4'd2;
        exc_pc    = 64'h8000_0010;
        exc_tval  = 64'hDEAD;
        push_trap(64'd2, 64'h8000_0010, 64'hDEAD, 64'h100);
        @(negedge clk);
        exc_valid = 1'b0;
        expect_trap("exc_illegal");

        // Timer interrupt held off by quiescent, vectored mtvec.
        mstatus   = 64'h8;
        mie       = 32'h80;
        mip       = 32'h80;
        mtvec     = 64'h201;
        quiescent = 1'b0;
        push_trap(Irq | 64'd7, next_pc, 64'd0, 64'h21C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("waitq_stall", {63'd0, stall}, 64'd1);
            chk("waitq_no_trap", {63'd0, trap_do_update}, 64'd0);
        end
        quiescent = 1'b1;
        @(negedge clk);
        expect_trap("mti_vec");

        // Priority: MEI over MTI over platform.
        mtvec   = 64'h100;
        mstatus = 64'h8;
        mie     = 32'hFFFF_FFFF;
        mip     = (32'd1 << 11) | (32'd1 << 7) | (32'd1 << 16);
        push_trap(Irq | 64'd11, next_pc, 64'd0, 64'h100);
        @(negedge clk);
        expect_trap("prio_mei");
        mstatus = 64'h8;
        mip     = (32'd1 << 7) | (32'd1 << 16);
        push_trap(Irq | 64'd7, next_pc, 64'd0, 64'h100);
        @(negedge clk);
        expect_trap("prio_mti");
        mstatus = 64'h8;
        mtvec   = 64'h101;
        mip     = (32'd1 << 16) | (32'd1 << 20) | (32'd1 << 5);
        push_trap(Irq | 64'd16, next_pc, 64'd0, 64'h140);
        @(negedge clk);
        expect_trap("prio_plat");

        // M-mode with MIE clear: pending interrupt not taken.
        mtvec   = 64'h100;
        mstatus = 64'h0;
        mip     = 32'h80;
        repeat (2) @(negedge clk);
        chk("masked_stall", {63'd0, stall}, 64'd0);
        chk("masked_trap", {63'd0, trap_do_update}, 64'd0);
        mip = '0;

        // Winner changes while waiting for quiescence.
        mstatus   = 64'h8;
        mip       = 32'h80;
        quiescent = 1'b0;
        @(negedge clk);
        chk("wq_chg_stall", {63'd0, stall}, 64'd1);
        mip       = mip | (32'd1 << 11);
        next_pc   = 64'h8000_0200;
        quiescent = 1'b1;
        push_trap(Irq | 64'd11, 64'h8000_0200, 64'd0, 64'h100);
        @(negedge clk);
        expect_trap("wq_winner");

        // Interrupt vanishes while waiting.
        mstatus   = 64'h8;
        mip       = 32'h80;
        quiescent = 1'b0;
        @(negedge clk);
        chk("wq_van_stall", {63'd0, stall}, 64'd1);
        mip       = '0;
        quiescent = 1'b1;
        @(negedge clk);
        chk("wq_van_idle", {63'd0, stall}, 64'd0);
        chk("wq_van_trap", {63'd0, trap_do_update}, 64'd0);

        // MRET to U-mode.
        mstatus    = 64'h80;
        mepc       = 64'h4000;
        mie        = '0;
        mret_valid = 1'b1;
        x.mstatus  = xret_model(64'h80);
        x.priv     = 2'd0;
        x.target   = 64'h4000;
        xret_q.push_back(x);
        @(negedge clk);
        mret_valid = 1'b0;
        expect_xret("mret_u");

        // MRET staying in M-mode with MPIE clear.
        mstatus    = 64'h1802;
        mepc       = 64'h5000;
        mret_valid = 1'b1;
        x.mstatus  = xret_model(64'h1802);
        x.priv     = 2'd3;
        x.target   = 64'h5000;
        xret_q.push_back(x);
        @(negedge clk);
        mret_valid = 1'b0;
        expect_xret("mret_m");

        // MRET unmasks a pending MSI: redirect straight into a trap.
        mstatus    = 64'h80;
        mepc       = 64'h4000;
        mie        = 32'h8;
        mip        = 32'h8;
        mtvec      = 64'h100;
        mret_valid = 1'b1;
        @(negedge clk);
        mret_valid = 1'b0;
        chk("unmask_xret", {63'd0, xret_do_update}, 64'd1);
        chk("unmask_no_trap", {63'd0, trap_do_update}, 64'd0);
        mstatus        = 64'h88;
        privilege_mode = 2'd0;
        push_trap(Irq | 64'd3, 64'h4000, 64'd0, 64'h100);
        @(negedge clk);
        chk("unmask_redir_v", {63'd0, redirect_valid}, 64'd1);
        chk("unmask_redir_pc", redirect_pc, 64'h4000);
        chk("unmask_xc_redir", {63'd0, xret_completing}, 64'd1);
        @(negedge clk);
        chk("unmask_xc_trap", {63'd0, xret_completing}, 64'd1);
        expect_trap("unmask_msi");
        privilege_mode = 2'd3;
        mie            = '0;

        // Exception and MRET in the same cycle: exception wins.
        mstatus    = 64'h80;
        exc_valid  = 1'b1;
        mret_valid = 1'b1;
        exc_cause  = 4'd3;
        exc_pc     = 64'h1234;
        exc_tval   = 64'h55;
        push_trap(64'd3, 64'h1234, 64'h55, 64'h100);
        @(negedge clk);
        exc_valid  = 1'b0;
        mret_valid = 1'b0;
        expect_trap("exc_vs_mret");

        // Reset while waiting for quiescence.
        mstatus   = 64'h8;
        mie       = 32'h80;
        mip       = 32'h80;
        quiescent = 1'b0;
        @(negedge clk);
        chk("rstwq_stall", {63'd0, stall}, 64'd1);
        rst = 1'b0;
        mip = '0;
        @(negedge clk);
        chk("rstwq_stall0", {63'd0, stall}, 64'd0);
        chk("rstwq_trap0", {63'd0, trap_do_update}, 64'd0);
        chk("rstwq_redir0", {63'd0, redirect_valid}, 64'd0);
        rst       = 1'b1;
        quiescent = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstwq_after_trap", {63'd0, trap_do_update}, 64'd0);
        chk("rstwq_after_stall", {63'd0, stall}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer and the producer side of the CSR file's trap/xret update interface.
- Consumes exceptions from exec, MRET commits and the CSR file's mstatus/mie/mip/mtvec/mepc/privilege state.
- Decides when a trap or MRET is taken, emits the single-cycle trap_do_update/xret_do_update pulses with their payloads, and redirects/flushes the front end.
- Single-hart, M/U only; no S mode, no delegation.

Parameters:
XLEN, 64, data/CSR width
ALEN, 64, address width
INTR_LEN, 32, interrupt vector width (bits 15:0 standard, 31:16 platform)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk)
exc_valid  in  1  exec reports an exception this cycle
exc_cause  in  4  exception cause code
exc_pc  in  ALEN  PC of faulting instruction
exc_tval  in  XLEN  trap value
mret_valid  in  1  MRET reaches commit this cycle
next_pc  in  ALEN  PC of next instruction to execute (mepc for interrupts)
quiescent  in  1  no in-flight memory ops; interrupts may only be taken when 1
privilege_mode  in  2  current privilege
mstatus  in  XLEN  CSR mstatus
mie  in  INTR_LEN  CSR mie
mip  in  INTR_LEN  CSR mip
mtvec  in  XLEN  CSR mtvec
mepc  in  ALEN  CSR mepc
trap_do_update  out  1  one-cycle pulse: CSR file latches trap payload
trap_mcause  out  XLEN  mcause value
trap_mepc  out  ALEN  mepc value
trap_mtval  out  XLEN  mtval value
xret_do_update  out  1  one-cycle pulse: CSR file latches xret payload
xret_completing  out  1  MRET redirect cycle in progress
xret_new_mstatus  out  XLEN  mstatus after MRET
xret_new_privilege_mode  out  2  privilege after MRET
redirect_valid  out  1  one-cycle pulse: fetch restarts at redirect_pc
redirect_pc  out  ALEN  target PC
stall  out  1  hold exec/commit (high in any non-IDLE state)

Behaviour:
- All outputs registered. Reset: state=IDLE; all pulses, stall and xret_completing 0; payload outputs 0.
- States: IDLE, WAIT_Q, TRAP, XRET, REDIRECT.
- Interrupt eligibility: pend = mie & mip; globally enabled iff privilege_mode<3 or mstatus[3].
- Interrupt selection order: 11 (MEI), 3 (MSI), 7 (MTI), then platform bits 16..INTR_LEN-1, lowest index first. Other bits ignored.
- IDLE priority, same cycle: exc_valid > mret_valid > enabled pending interrupt.
- IDLE + exc_valid: latch mcause={0,cause}, mepc=exc_pc, mtval=exc_tval; go TRAP.
- IDLE + mret_valid (no exc): go XRET.
- IDLE + interrupt, quiescent=1: latch mcause={1,0..,id}, mepc=next_pc, mtval=0; go TRAP.
- IDLE + interrupt, quiescent=0: go WAIT_Q.
- WAIT_Q: stall=1. On quiescent=1, re-evaluate selection (the winner may change, or the interrupt may vanish). Interrupt present: latch and go TRAP. Vanished: go IDLE.
- TRAP: trap_do_update=1 for exactly this cycle; go REDIRECT.
  - Target = mtvec & ~3.
  - If mtvec[1:0]==1 and the trap is an interrupt: target = base + 4*id, ALEN wrap.
- XRET:
  - xret_do_update=1 for exactly this cycle.
  - new mstatus = mstatus with MIE[3]=MPIE[7], MPIE=1, MPP[12:11]=00.
  - new privilege = mstatus[12:11].
  - Target = mepc; go REDIRECT with xret_completing=1.
- REDIRECT: redirect_valid=1 for this cycle; xret_completing held if arriving from XRET. Next state IDLE, with one exception:
  - If an enabled interrupt exists here (e.g. unmasked by the MRET), go directly to TRAP.
  - Latch mepc=the MRET target (mepc); xret_completing stays high through that TRAP cycle.
- trap_do_update and xret_do_update never assert in the same cycle.
- exc_valid/mret_valid outside IDLE are ignored; stall guarantees exec does not issue them.
- Reset in any state returns to IDLE the next edge; a pending pulse is dropped.

Test Plan:
- Illegal-instr exc_valid, cause 2, exc_pc=0x8000_0010, tval=0xDEAD, mtvec=0x100 → trap_do_update one cycle later with mcause=2, mepc=0x8000_0010, mtval=0xDEAD; next cycle redirect_pc=0x100.
- MTI pending+enabled, mstatus.MIE=1, mtvec=0x201 (vectored), quiescent=0 for 3 cycles → stall 3 cycles, then mcause=0x8000_0000_0000_0007, redirect_pc=0x21C.
- MEI+MTI+platform bit 16 all pending → mcause id 11; clear MEI, retake → 7; clear MTI → 16.
- MRET with mstatus MPP=00, MPIE=1, mepc=0x4000 → xret_new_mstatus MIE=1, MPIE=1, MPP=00; priv 0; redirect_pc=0x4000.
- MRET that unmasks pending MSI → REDIRECT then TRAP with xret_completing=1, mepc=0x4000, mcause id 3; never both update pulses together.
- exc_valid and mret_valid same cycle → exception taken, no xret_do_update; rst=0 mid-WAIT_Q → IDLE, no pulses.
